// File: rtl/lfsr_5bit_gen_pkg.sv
// Shared constants and next-state helper for the 5-bit Fibonacci LFSR (x^5 + x^3 + 1).
package lfsr_5bit_gen_pkg;

  localparam int LFSR_W      = 5;
  localparam int LFSR_PERIOD = 31;
  localparam int TAP_HI      = 4;
  localparam int TAP_LO      = 2;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 5'h01;

  // Left-shift Fibonacci step: the feedback bit enters at the LSB.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], q[TAP_HI] ^ q[TAP_LO]};
  endfunction

endpackage

// File: rtl/lfsr_5bit_gen.sv
// Free-running maximal-length LFSR with a step enable, a zero-protected seed load
// and a guard that recovers from the all-zero lock-up state.
module lfsr_5bit_gen
  import lfsr_5bit_gen_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed_in,
  output logic [LFSR_W-1:0] prn
);

  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_5bit_gen: SEED must be nonzero");
  end

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  // Load takes precedence over stepping; a zero seed or zero state falls back to SEED.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = (seed_in != '0) ? seed_in : SEED;
    end else if (en) begin
      lfsr_d = (lfsr_q == '0) ? SEED : lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign prn = lfsr_q;

endmodule

// File: tb/tb_lfsr_5bit_gen.sv
// Directed and randomized checks of lfsr_5bit_gen against an arithmetic reference model.
module tb_lfsr_5bit_gen;

  localparam int SEED_V = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [4:0] seed_in = 5'h00;
  logic [4:0] prn;

  int n_cmp = 0;
  int n_err = 0;
  int m_state = 0;

  lfsr_5bit_gen #(.SEED(5'h01)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .load    (load),
    .seed_in (seed_in),
    .prn     (prn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Polynomial x^5 + x^3 + 1 evaluated arithmetically: double modulo 32, add bit4 xor bit2.
  function automatic int model_next(input int v);
    return ((v * 2) % 32) + (((v / 16) % 2) ^ ((v / 4) % 2));
  endfunction

  // Apply one cycle of controls, advance the model by the priority rules, compare prn.
  task automatic cyc(input logic r, input logic l, input logic e, input logic [4:0] s,
                     input string tag);
    rst = r; load = l; en = e; seed_in = s;
    @(posedge clk);
    #1;
    if (r)      m_state = SEED_V;
    else if (l) m_state = (s != 0) ? int'(s) : SEED_V;
    else if (e) m_state = (m_state == 0) ? SEED_V : model_next(m_state);
    chk(tag, int'(prn), m_state);
  endtask

  int ref_seq [7] = '{'h01, 'h02, 'h04, 'h09, 'h12, 'h05, 'h0B};
  int seen [32];
  int uniq;
  int zeros;
  int ret_step;

  initial begin
    // Reset then run
    cyc(1'b1, 1'b0, 1'b0, 5'h00, "reset1");
    cyc(1'b1, 1'b0, 1'b0, 5'h00, "reset2");
    chk("reset_val", int'(prn), 'h01);
    for (int i = 1; i < 7; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 5'h00, "run");
      chk("ref_seq", int'(prn), ref_seq[i]);
    end

    // Period: from SEED, 31 steps
    cyc(1'b1, 1'b0, 1'b0, 5'h00, "reset3");
    for (int v = 0; v < 32; v++) seen[v] = 0;
    zeros = 0;
    ret_step = -1;
    for (int i = 1; i <= 31; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 5'h00, "period_run");
      seen[prn]++;
      if (prn == 5'h00) zeros++;
      if (prn == 5'h01 && ret_step < 0) ret_step = i;
    end
    uniq = 0;
    for (int v = 1; v < 32; v++) if (seen[v] == 1) uniq++;
    chk("period_return", ret_step, 31);
    chk("period_unique", uniq, 31);
    chk("period_no_zero", zeros, 0);

    // Enable hold at 09
    cyc(1'b1, 1'b0, 1'b0, 5'h00, "reset4");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 5'h00, "to09");
    chk("at09", int'(prn), 'h09);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 5'h00, "hold");
      chk("hold09", int'(prn), 'h09);
    end
    cyc(1'b0, 1'b0, 1'b1, 5'h00, "resume");
    chk("resume12", int'(prn), 'h12);

    // Seed load with en: load wins
    cyc(1'b0, 1'b1, 1'b1, 5'h1F, "load1F");
    chk("load1F_val", int'(prn), 'h1F);
    cyc(1'b0, 1'b0, 1'b1, 5'h00, "after1F");
    chk("step1E", int'(prn), 'h1E);

    // Zero seed falls back to SEED
    cyc(1'b0, 1'b1, 1'b0, 5'h00, "load00");
    chk("zero_seed", int'(prn), 'h01);
    cyc(1'b0, 1'b0, 1'b1, 5'h00, "zs_step1");
    chk("zs02", int'(prn), 'h02);
    cyc(1'b0, 1'b0, 1'b1, 5'h00, "zs_step2");
    chk("zs04", int'(prn), 'h04);

    // Mid-run reset beats a simultaneous load
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 5'h00, "to0B");
    chk("at0B", int'(prn), 'h0B);
    cyc(1'b1, 1'b1, 1'b1, 5'h07, "rst_vs_load");
    chk("rst_wins", int'(prn), 'h01);
    cyc(1'b0, 1'b0, 1'b1, 5'h00, "post_rst");
    chk("post_rst02", int'(prn), 'h02);

    // Randomized control mix
    for (int i = 0; i < 400; i++) begin
      logic r, l, e;
      logic [4:0] s;
      r = ($urandom_range(0, 31) == 0);
      l = ($urandom_range(0, 7) == 0);
      e = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 3) == 0) ? 5'h00 : 5'($urandom_range(1, 31));
      cyc(r, l, e, s, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lfsr_5bit_gen.md
Name: lfsr_5bit_gen

Overview:
- 5-bit maximal-length Fibonacci LFSR that supplies a pseudo-random number `prn` every clock.
- The game top level uses `prn` to pick the column of newly spawned falling objects.
- It is free-running by default. It also supports a step enable and a synchronous seed load for repeatable sequences.
- The all-zero lock-up state is impossible by construction.

Parameters:
- SEED, default 5'h01: reset and fallback state. Must be nonzero; an elaboration-time check fails if SEED == 0.

Ports:
- clk, input, 1: system clock; all state changes on its rising edge.
- rst, input, 1: reset, synchronous, active-high.
- en, input, 1: step enable. Tie to 1 for free-running operation, which is the top-level usage.
- load, input, 1: synchronous seed load strobe.
- seed_in, input, 5: seed value, used when load=1.
- prn, output, 5: current LFSR state, driven directly from the register (no combinational path from inputs).

Behaviour:
- Polynomial: x^5 + x^3 + 1.
- Left-shift Fibonacci update: next = {q[3:0], q[4] ^ q[2]}.
- Period: 31. All nonzero states are visited; 5'h00 never appears while running.
- Priority at each rising edge of clk: rst, then load, then en, then hold.
- rst=1: q <= SEED. prn equals SEED from the next cycle. load and en are ignored that cycle.
- load=1 (rst=0):
  - q <= seed_in if seed_in != 0.
  - q <= SEED if seed_in == 0 (zero-seed protection).
  - The load cycle does not also step the register.
- en=1 (rst=0, load=0): q <= next(q).
- en=0, load=0, rst=0: q holds.
- Lock-up guard: if q is ever 5'h00 (e.g. power-up without reset, or an X-free sim start), the next enabled step loads SEED instead of next(q).
- Latency: one clock from any control input to prn.
- Reference sequence from 5'h01, en=1: 01, 02, 04, 09, 12, 05, 0B, ... then back to 01 after 31 steps.
- Reset in mid-sequence returns q to SEED on that edge. Stepping resumes from SEED on the following enabled edge.
- Simultaneous load and en: load wins and no step occurs.
- Power-up value before the first reset is undefined. Until then the block must not be relied on, apart from the lock-up guard above.

Decomposition:
- Shared package holds:
  - LFSR_W = 5
  - LFSR_PERIOD = 31
  - the tap positions (4, 2)
  - the default seed constant 5'h01
- No sub-module: a single flat module with one state register and its next-state logic.
- A small combinational function for next(q) may be defined in the package for reuse by the scoreboard model.

Test Plan:
- Reset then run: rst=1 for 2 cycles, then en=1. prn reads 01 after reset, then 02, 04, 09, 12, 05, 0B on successive cycles.
- Period check: from SEED, with en=1 for 31 cycles:
  - prn returns to 01 exactly at step 31;
  - all 31 nonzero values appear exactly once;
  - 00 never appears.
- Enable hold: en=0 for 10 cycles at prn=09. prn stays 09. Re-asserting en gives 12 next.
- Seed load: load=1, seed_in=1F, en=1 in the same cycle. prn=1F next cycle with no step. The following enabled cycle gives 1E (feedback 1^1=0).
- Zero seed: load=1, seed_in=00. prn=01 (SEED) next cycle, and the sequence continues 02, 04.
- Mid-run reset: at prn=0B assert rst together with load=1, seed_in=07. prn=01 next cycle (reset wins), then 02 when en=1.
